// File: rtl/srff_pkg.sv
// Shared types and the per-bit SR excitation rule for the srff_drv write path.
package srff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef struct packed {
    logic s;
    logic r;
  } sr_t;

  // Set only to raise a 0 to 1, reset only to drop a 1 to 0; never both.
  function automatic sr_t excite(input logic t, input logic q);
    sr_t p;
    p.s = t & ~q;
    p.r = ~t & q;
    return p;
  endfunction

endpackage

// File: rtl/srff_excite.sv
// Combinational WIDTH-wide S/R excitation from a target word and the bank readback.
module srff_excite
  import srff_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  sr_t p;

  always_comb begin
    s = '0;
    r = '0;
    p = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      p    = excite(tgt[i], q[i]);
      s[i] = p.s;
      r[i] = p.r;
    end
  end

endmodule

// File: rtl/srff_drv.sv
// Drives S/R excitation into a negedge SR flip-flop bank, verifies by readback,
// retries a bounded number of times and reports done or err.
module srff_drv
  import srff_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int unsigned CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] RETRY_LIMIT = CW'(MAX_RETRY);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic [CW-1:0]    retry_cnt;
  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] exc_s;
  logic [WIDTH-1:0] exc_r;
  logic             match;
  logic             at_limit;

  // One excitation instance serves both the accept and the retry reload.
  assign exc_tgt  = (state == IDLE) ? tgt_data : tgt_q;
  assign match    = (q_fb == tgt_q);
  assign at_limit = (retry_cnt == RETRY_LIMIT);

  srff_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .tgt(exc_tgt),
    .q  (q_fb),
    .s  (exc_s),
    .r  (exc_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tgt_valid) state_nxt = DRIVE;
      DRIVE:   state_nxt = CHECK;
      CHECK:   state_nxt = (match || at_limit) ? IDLE : DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state == IDLE) & ~rst;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      r         <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_mask  <= '0;
      tgt_q     <= '0;
      retry_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_q     <= tgt_data;
            retry_cnt <= '0;
            s         <= exc_s;
            r         <= exc_r;
          end
        end
        DRIVE: begin
          s <= '0;
          r <= '0;
        end
        CHECK: begin
          if (match) begin
            done <= 1'b1;
          end else if (at_limit) begin
            err      <= 1'b1;
            err_mask <= q_fb ^ tgt_q;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            s         <= exc_s;
            r         <= exc_r;
          end
        end
        default: begin
          s <= '0;
          r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srff_drv.sv
// Bench for srff_drv: a negedge SR bank with stuck-at-0 injection, directed table and random targets.
module tb_srff_drv;

  localparam int unsigned W  = 8;
  localparam int unsigned MR = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic         tgt_ready;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic [W-1:0] q_fb;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] err_mask;

  logic         bank_rst;
  logic [W-1:0] bank;
  logic [W-1:0] stuck;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] model_bank;

  srff_drv #(
    .WIDTH    (W),
    .MAX_RETRY(MR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_valid(tgt_valid),
    .tgt_data (tgt_data),
    .tgt_ready(tgt_ready),
    .s        (s),
    .r        (r),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_mask (err_mask)
  );

  always #5 clk = ~clk;

  // Bank of negedge SR flops; stuck bits can never be set.
  always_ff @(negedge clk) begin
    if (bank_rst) bank <= '0;
    else          bank <= ((bank & ~r) | s) & ~stuck;
  end
  assign q_fb = bank & ~stuck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // S and R must never be raised together, sampled on both clock phases.
  always @(negedge clk) chk("s_and_r_neg", {24'd0, s & r}, 32'd0);
  always @(posedge clk) begin
    #2;
    chk("s_and_r_pos", {24'd0, s & r}, 32'd0);
  end

  typedef struct {
    logic [W-1:0] t;
    logic [W-1:0] sm;
    logic [W-1:0] es;
    logic [W-1:0] er;
    bit           eerr;
    logic [W-1:0] emask;
    int           elat;
    int           edrv;
  } vec_t;

  // Outcome from the bank's view: stuck bits that must become 1 can never match.
  task automatic predict(input logic [W-1:0] t, input logic [W-1:0] sm, output vec_t v);
    logic [W-1:0] qv;
    qv     = model_bank & ~sm;
    v.t    = t;
    v.sm   = sm;
    v.es   = t & ~qv;
    v.er   = ~t & qv;
    v.emask = t & sm;
    v.eerr = (v.emask != '0);
    v.elat = v.eerr ? 3 + 2 * MR : 3;
    v.edrv = v.eerr ? MR + 1 : (((v.es | v.er) != '0) ? 1 : 0);
  endtask

  // Called #1 after a posedge while the DUT is idle; returns in the done/err cycle.
  task automatic run_txn(input vec_t v);
    int cyc;
    int drv;
    stuck      = v.sm;
    model_bank = model_bank & ~v.sm;
    chk("ready_at_accept", {31'd0, tgt_ready}, 32'd1);
    tgt_valid = 1'b1;
    tgt_data  = v.t;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    cyc = 1;
    drv = 0;
    chk("drive_s", {24'd0, s}, {24'd0, v.es});
    chk("drive_r", {24'd0, r}, {24'd0, v.er});
    chk("drive_busy", {31'd0, busy}, 32'd1);
    chk("pulse_dropped", {30'd0, done, err}, 32'd0);
    while (cyc <= 40) begin
      if ((s | r) != '0) drv++;
      if (done || err) break;
      tgt_valid = 1'($urandom_range(0, 1));
      tgt_data  = W'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    tgt_valid = 1'b0;
    chk("latency", cyc, v.elat);
    chk("drive_count", drv, v.edrv);
    chk("done", {31'd0, done}, {31'd0, !v.eerr});
    chk("err", {31'd0, err}, {31'd0, v.eerr});
    chk("ready_in_end_cycle", {31'd0, tgt_ready}, 32'd1);
    if (v.eerr) chk("err_mask", {24'd0, err_mask}, {24'd0, v.emask});
    model_bank = v.t & ~v.sm;
    chk("bank", {24'd0, q_fb}, {24'd0, model_bank});
  endtask

  vec_t tbl[5];
  vec_t v;

  initial begin
    rst       = 1'b1;
    bank_rst  = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    stuck     = '0;
    model_bank = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", {24'd0, s}, 32'd0);
    chk("rst_r", {24'd0, r}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("rst_err_mask", {24'd0, err_mask}, 32'd0);
    rst      = 1'b0;
    bank_rst = 1'b0;
    @(posedge clk); #1;

    //            t       sm      s       r       err   mask   lat drv
    tbl[0] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 8'h00, 3, 1};
    tbl[1] = '{8'h3C, 8'h00, 8'h18, 8'h81, 1'b0, 8'h00, 3, 1};
    tbl[2] = '{8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 3, 0};
    tbl[3] = '{8'hFF, 8'h01, 8'hC3, 8'h00, 1'b1, 8'h01, 9, 4};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 8'hFE, 1'b0, 8'h00, 3, 1};
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // Reset during DRIVE aborts silently and leaves the bank untouched.
    @(posedge clk); #1;
    tgt_valid = 1'b1;
    tgt_data  = 8'h5A;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    chk("abort_drive_s", {24'd0, s}, 32'h5A);
    rst = 1'b1;
    #1;
    chk("abort_s", {24'd0, s}, 32'd0);
    chk("abort_r", {24'd0, r}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (done || err) seen++;
        @(posedge clk); #1;
      end
      chk("abort_no_pulse", seen, 0);
    end
    chk("abort_bank", {24'd0, q_fb}, {24'd0, model_bank});
    predict(8'h96, 8'h00, v);
    run_txn(v);

    // Random back-to-back targets, each accepted in the previous done/err cycle.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] sm;
      sm = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      predict(W'($urandom), sm, v);
      run_txn(v);
    end

    @(posedge clk); #1;
    chk("final_idle", {29'd0, busy, done, err}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/srff_drv.md
# srff_drv

Excitation driver for a bank of negative-edge SR flip-flops. It accepts a target word over a valid/ready handshake and computes the per-bit S/R excitation from the bank's current Q readback. It drives that excitation for one clock, then verifies the bank by readback. On mismatch it retries up to a fixed count, then flags an error. It is the write-side counterpart of the codebase's SR storage cells: the cells consume S/R, and this block produces S/R.

## Interface
- WIDTH, 8: number of SR flip-flops in the driven bank.
- MAX_RETRY, 3: extra drive attempts after the first mismatch; 0 means one attempt only.

- clk  in  1  posedge clock for all block state.
- rst  in  1  asynchronous, active-high reset.
- tgt_valid  in  1  target word offered.
- tgt_data  in  WIDTH  desired Q value for the bank.
- tgt_ready  out  1  block can accept a target; high only in IDLE.
- s  out  WIDTH  set inputs to the bank; registered.
- r  out  WIDTH  reset inputs to the bank; registered.
- q_fb  in  WIDTH  Q readback from the bank.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: the bank matches the target.
- err  out  1  one-cycle pulse: retries are exhausted.
- err_mask  out  WIDTH  value of q_fb ^ target, captured when err fires; held until the next err or reset.

## Operation
- Excitation rule, per bit i, with target t and readback q:
  - q=0, t=1: s=1, r=0.
  - q=1, t=0: s=0, r=1.
  - Otherwise: s=0, r=0 (hold).
- Invariant: s[i]&r[i] is never 1, in any state, including during reset.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid: latch tgt_data into tgt_q, clear retry_cnt, load s/r from the excitation of (tgt_data, q_fb), go to DRIVE.
- DRIVE (1 cycle):
  - s/r are held.
  - The bank captures them on the negedge inside this cycle.
  - At the next posedge: s,r <= 0, go to CHECK.
- CHECK (1 cycle), compare q_fb to tgt_q:
  - Equal: done<=1, go to IDLE.
  - Not equal and retry_cnt==MAX_RETRY: err<=1, err_mask<=q_fb^tgt_q, go to IDLE.
  - Otherwise: retry_cnt++, reload s/r from the excitation of (tgt_q, q_fb), go to DRIVE.
- tgt_data is ignored outside IDLE. tgt_q is stable from accept until return to IDLE.
- retry_cnt width is $clog2(MAX_RETRY+1), minimum 1. It saturates by construction and never wraps.
- A target equal to the current q_fb still goes through DRIVE with s=r=0 and CHECK, then completes with done.

## Timing
- Reset (async, immediate) sets:
  - state=IDLE.
  - s=0, r=0.
  - done=0, err=0, busy=0.
  - err_mask=0, tgt_q=0, retry_cnt=0.
  - tgt_ready=1 once rst deasserts.
- Reset mid-operation:
  - s/r drop to 0 immediately.
  - No done or err is issued for the aborted target.
- Latency:
  - Accept at edge 0, DRIVE in cycle 1, CHECK in cycle 2, done high in cycle 3.
  - Each retry adds 2 cycles.
  - Worst case to err: 3 + 2·MAX_RETRY cycles.
- done and err are high for exactly one cycle: the first IDLE cycle after the operation.
  - tgt_ready is also high in that cycle, so a new accept in the same cycle is legal.
  - Back-to-back throughput is one target per 3 cycles.
- done and err are never both high in the same cycle.
- q_fb is sampled at posedge only. The bank's negedge update settles within a half cycle.

## Structure
- Package srff_pkg holds:
  - The state enum: IDLE, DRIVE, CHECK.
  - An excite function (t, q) returning the {s, r} pair.
- Sub-module srff_excite: purely combinational, WIDTH-wide excitation from (target, q). It is used at the IDLE accept and at the CHECK retry.
- Top level: the FSM, s/r registers, retry counter, and done/err/err_mask registers.

## Test plan
- Bench load: a bank of WIDTH negedge SR flops with synchronous active-high reset, q_fb = bank Q.
- Reset then target 0xA5 from bank=0x00:
  - In DRIVE, s=0xA5 and r=0x00.
  - done in cycle 3, err=0, bank=0xA5.
- Bank at 0xA5, target 0x3C:
  - s=0x18, r=0x81.
  - done after 3 cycles, bank=0x3C.
- Target equal to current bank value (0x3C):
  - s=r=0 throughout.
  - done after 3 cycles.
- Bit 0 of the bank forced stuck at 0, target 0xFF, MAX_RETRY=3:
  - Four DRIVE cycles occur.
  - err at cycle 9, err_mask=0x01, done never asserted.
- rst asserted during DRIVE:
  - s=r=0 in the same cycle, busy=0.
  - No done or err.
  - The next target completes normally.
- Every cycle of every scenario: assert (s & r)==0. Also assert a new tgt_valid accepted in the done cycle yields a following done 3 cycles later.
